// File: rtl/dnn_sample_streamer.sv
// Ping-pong sample buffer that replays each stored training sample to the DNN input layer
// in lock-step with a private cycle-block counter (one sample per cpc-clock block).
module dnn_sample_streamer #(
    parameter int WIDTH_IN = 8,
    parameter int N0       = 1024,
    parameter int FO0      = 8,
    parameter int Z0       = 512,
    parameter int NL       = 16,
    parameter int ZL       = 1,
    parameter int EPW      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH_IN*Z0/FO0-1:0]   in_data,
    input  logic                         in_first,
    input  logic [$clog2(NL)-1:0]        in_label,
    input  logic [EPW-1:0]               in_etapos,
    output logic [WIDTH_IN*Z0/FO0-1:0]   act0,
    output logic [ZL-1:0]                ans0,
    output logic [EPW-1:0]               etapos0,
    output logic                         blk_valid,
    output logic [15:0]                  underrun_cnt,
    output logic [31:0]                  sent_cnt,
    output logic                         proto_err
);

    localparam int CW     = WIDTH_IN * Z0 / FO0;
    localparam int NCHUNK = N0 * FO0 / Z0;
    localparam int CPC    = NCHUNK + 2;
    localparam int IDX_W  = $clog2(NCHUNK);
    localparam int CNT_W  = $clog2(CPC);
    localparam int LW     = $clog2(NL);

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } bank_st_t;

    bank_st_t             st_q [2];
    bank_st_t             st_d [2];
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 in_ready_q, in_ready_d;
    logic [CW-1:0]        act0_q, act0_d;
    logic [ZL-1:0]        ans0_q, ans0_d;
    logic [EPW-1:0]       etapos0_q, etapos0_d;
    logic                 blk_valid_q, blk_valid_d;
    logic [15:0]          underrun_q, underrun_d;
    logic [31:0]          sent_q, sent_d;
    logic                 perr_q, perr_d;

    // Sample storage: bank select is the MSB of the chunk address
    logic [CW-1:0]        mem [2*NCHUNK];
    logic [LW-1:0]        lab_q [2];
    logic [EPW-1:0]       etp_q [2];

    logic                 accept;
    logic                 cnt_end;
    logic                 cand;
    logic                 wr_en;
    logic                 lab_we;
    logic [IDX_W-1:0]     wr_idx;

    assign accept  = in_valid & in_ready_q;
    assign cnt_end = (cnt_q == CNT_W'(CPC - 1));

    always_comb begin
        st_d        = st_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        idx_d       = idx_q;
        blk_valid_d = blk_valid_q;
        underrun_d  = underrun_q;
        sent_d      = sent_q;
        perr_d      = 1'b0;
        wr_en       = 1'b0;
        lab_we      = 1'b0;
        wr_idx      = idx_q;
        cand        = rd_bank_q;
        cnt_d       = cnt_end ? '0 : cnt_q + CNT_W'(1);

        // Write side only ever touches an EMPTY or FILLING bank
        if (accept) begin
            if (in_first) begin
                perr_d           = (st_q[wr_bank_q] == B_FILLING);
                wr_en            = 1'b1;
                wr_idx           = '0;
                lab_we           = 1'b1;
                idx_d            = IDX_W'(1);
                st_d[wr_bank_q]  = B_FILLING;
            end else if (st_q[wr_bank_q] == B_EMPTY) begin
                perr_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    st_d[wr_bank_q] = B_FULL;
                    wr_bank_d       = ~wr_bank_q;
                    idx_d           = '0;
                end
            end
        end

        // Read side only ever touches a FULL or READING bank, so no conflict with writes
        if (cnt_end) begin
            if (st_q[rd_bank_q] == B_READING) begin
                st_d[rd_bank_q] = B_EMPTY;
                cand            = ~rd_bank_q;
            end
            rd_bank_d = cand;
            if (st_q[cand] == B_FULL) begin
                st_d[cand]  = B_READING;
                blk_valid_d = 1'b1;
                sent_d      = sent_q + 32'd1;
            end else begin
                blk_valid_d = 1'b0;
                if (underrun_q != 16'hFFFF) begin
                    underrun_d = underrun_q + 16'd1;
                end
            end
        end

        in_ready_d = (st_d[wr_bank_d] == B_EMPTY) || (st_d[wr_bank_d] == B_FILLING);

        // Outputs are computed for the next counter value so they line up with cnt
        act0_d = '0;
        if (blk_valid_d && (int'(cnt_d) < NCHUNK)) begin
            act0_d = mem[{rd_bank_d, cnt_d[IDX_W-1:0]}];
        end
        etapos0_d = blk_valid_d ? etp_q[rd_bank_d] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < ZL; gi++) begin : g_ans
            assign ans0_d[gi] = blk_valid_d && (int'(cnt_d) < NL / ZL) &&
                                (int'(lab_q[rd_bank_d]) == int'(cnt_d) * ZL + gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_idx}] <= in_data;
        end
        if (lab_we) begin
            lab_q[wr_bank_q] <= in_label;
            etp_q[wr_bank_q] <= in_etapos;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q[0]     <= B_EMPTY;
            st_q[1]     <= B_EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            act0_q      <= '0;
            ans0_q      <= '0;
            etapos0_q   <= '0;
            blk_valid_q <= 1'b0;
            underrun_q  <= '0;
            sent_q      <= '0;
            perr_q      <= 1'b0;
        end else begin
            st_q[0]     <= st_d[0];
            st_q[1]     <= st_d[1];
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            act0_q      <= act0_d;
            ans0_q      <= ans0_d;
            etapos0_q   <= etapos0_d;
            blk_valid_q <= blk_valid_d;
            underrun_q  <= underrun_d;
            sent_q      <= sent_d;
            perr_q      <= perr_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign act0         = act0_q;
    assign ans0         = ans0_q;
    assign etapos0      = etapos0_q;
    assign blk_valid    = blk_valid_q;
    assign underrun_cnt = underrun_q;
    assign sent_cnt     = sent_q;
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_dnn_sample_streamer.sv
// Scoreboard bench: the driver builds complete samples into an arrival-ordered queue,
// the monitor replays the expected block contents against the DUT clock by clock.
module tb_dnn_sample_streamer;

    localparam int CW     = 512;
    localparam int NCHUNK = 16;
    localparam int CPC    = 18;
    localparam int NL     = 16;
    localparam int LW     = 4;
    localparam int EPW    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_first = 1'b0;
    logic [CW-1:0]     in_data = '0;
    logic [LW-1:0]     in_label = '0;
    logic [EPW-1:0]    in_etapos = '0;
    logic              in_ready;
    logic [CW-1:0]     act0;
    logic [0:0]        ans0;
    logic [EPW-1:0]    etapos0;
    logic              blk_valid;
    logic [15:0]       underrun_cnt;
    logic [31:0]       sent_cnt;
    logic              proto_err;

    dnn_sample_streamer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_first(in_first), .in_label(in_label), .in_etapos(in_etapos),
        .act0(act0), .ans0(ans0), .etapos0(etapos0), .blk_valid(blk_valid),
        .underrun_cnt(underrun_cnt), .sent_cnt(sent_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;   // clock edges since reset release == expected DNN counter position
    bit saw_stall = 0;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Completed samples in arrival order, with the edge on which the last beat landed
    logic [NCHUNK*CW-1:0] pend_data [$];
    logic [LW-1:0]        pend_label [$];
    logic [EPW-1:0]       pend_etp [$];
    int                   pend_done [$];
    bit                   perr_at [int];

    logic [NCHUNK*CW-1:0] bld_data;
    logic [LW-1:0]        bld_label;
    logic [EPW-1:0]       bld_etp;
    int                   bld_n = 0;
    bit                   bld_active = 0;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cyc %0d: got %0h required %0h", name, cyc, got, exp);
    endtask

    function automatic logic [CW-1:0] rnd_chunk();
        logic [CW-1:0] r;
        for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_beat(input bit first, input logic [CW-1:0] d, input logic [LW-1:0] lb,
                              input logic [EPW-1:0] ep, input int e);
        if (first) begin
            if (bld_active) perr_at[e] = 1'b1;
            bld_active = 1'b1;
            bld_n      = 1;
            bld_data   = '0;
            bld_data[0 +: CW] = d;
            bld_label  = lb;
            bld_etp    = ep;
        end else if (!bld_active) begin
            perr_at[e] = 1'b1;
        end else begin
            bld_data[bld_n*CW +: CW] = d;
            bld_n++;
            if (bld_n == NCHUNK) begin
                pend_data.push_back(bld_data);
                pend_label.push_back(bld_label);
                pend_etp.push_back(bld_etp);
                pend_done.push_back(e);
                bld_active = 1'b0;
                $display("sample in : label=%0d etapos=%0d last beat edge=%0d", bld_label, bld_etp, e);
            end
        end
    endtask

    // Called at a falling edge; the beat is taken on the next rising edge when ready
    task automatic beat(input bit first, input logic [CW-1:0] d, input logic [LW-1:0] lb,
                        input logic [EPW-1:0] ep);
        int w = 0;
        in_valid = 1'b1; in_first = first; in_data = d; in_label = lb; in_etapos = ep;
        if (!in_ready) saw_stall = 1'b1;
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL beat_timeout: in_ready got 0 for 400 clocks, required 1");
        end else begin
            model_beat(first, d, lb, ep, cyc + 1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0;
    endtask

    task automatic send_sample(input logic [LW-1:0] lb, input logic [EPW-1:0] ep, input bit ramp);
        logic [7:0] kb;
        for (int k = 0; k < NCHUNK; k++) begin
            kb = 8'(k);
            beat(k == 0, ramp ? {64{kb}} : rnd_chunk(), lb, ep);
        end
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        in_valid = 1'b0; in_first = 1'b0;
        #1;
        chk("rst_act0", act0, '0);
        chk("rst_flags", {blk_valid, in_ready, proto_err, ans0, etapos0}, '0);
        chk("rst_counts", {underrun_cnt, sent_cnt}, '0);
        pend_data.delete(); pend_label.delete(); pend_etp.delete(); pend_done.delete();
        perr_at.delete();
        bld_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
    endtask

    // Monitor: expected block content follows solely from the sample queue and arrival times
    logic [NCHUNK*CW-1:0] cur_data;
    logic [LW-1:0]        cur_label;
    logic [EPW-1:0]       cur_etp;
    bit                   cur_valid = 0;
    int                   exp_under = 0;
    int                   exp_sent = 0;

    always @(negedge clk) begin
        int k;
        logic [CW-1:0] e_act;
        if (reset) begin
            cur_valid = 0; exp_under = 0; exp_sent = 0;
        end else begin
            k = cyc % CPC;
            if (k == 0 && cyc > 0) begin
                if (pend_done.size() > 0 && pend_done[0] < cyc) begin
                    cur_data  = pend_data.pop_front();
                    cur_label = pend_label.pop_front();
                    cur_etp   = pend_etp.pop_front();
                    void'(pend_done.pop_front());
                    cur_valid = 1;
                    exp_sent++;
                end else begin
                    cur_valid = 0;
                    if (exp_under < 65535) exp_under++;
                end
                chk("underrun_cnt", underrun_cnt, exp_under);
                chk("sent_cnt", sent_cnt, exp_sent);
            end
            e_act = (cur_valid && k < NCHUNK) ? cur_data[k*CW +: CW] : '0;
            chk("blk_valid", blk_valid, cur_valid);
            chk("act0", act0, e_act);
            chk("ans0", ans0, (cur_valid && k < NL && int'(cur_label) == k) ? 1 : 0);
            chk("etapos0", etapos0, cur_valid ? cur_etp : '0);
            chk("proto_err", proto_err, perr_at.exists(cyc) ? 1 : 0);
            if (k == CPC - 1)
                $display("block out: valid=%0d label=%0d etapos=%0d sent=%0d underrun=%0d",
                         cur_valid, cur_label, cur_etp, sent_cnt, underrun_cnt);
        end
    end

    initial begin
        int w;
        #1 reset = 1'b1;
        @(negedge clk);

        // Idle after reset: three bubble decisions in 54 clocks
        apply_reset();
        repeat (54) @(negedge clk);
        chk("underrun_after_54", underrun_cnt, 3);

        // Single ramp sample right after reset
        apply_reset();
        send_sample(4'd5, 4'd3, 1'b1);
        repeat (3 * CPC) @(negedge clk);

        // Back-to-back stream of four samples
        apply_reset();
        saw_stall = 0;
        send_sample(4'd0, 4'($urandom_range(0, 15)), 1'b0);
        send_sample(4'd15, 4'($urandom_range(0, 15)), 1'b0);
        send_sample(4'd7, 4'($urandom_range(0, 15)), 1'b0);
        send_sample(4'd7, 4'($urandom_range(0, 15)), 1'b0);
        repeat (2) @(negedge clk);
        chk("stream_no_bubble", underrun_cnt, 0);
        chk("stream_sent", sent_cnt, 4);
        chk("stream_backpressure", saw_stall, 1);
        repeat (4 * CPC) @(negedge clk);

        // Last beat lands exactly on the block-boundary edge
        w = 0;
        while (cyc % CPC != 1 && w < 100) begin @(negedge clk); w++; end
        in_label = 4'd11;
        for (int k = 0; k < NCHUNK - 1; k++) beat(k == 0, rnd_chunk(), 4'd11, 4'd9);
        while (cyc % CPC != CPC - 1 && w < 200) begin @(negedge clk); w++; end
        beat(1'b0, rnd_chunk(), 4'd11, 4'd9);
        repeat (3 * CPC) @(negedge clk);

        // Framing errors: restart at beat 9, then a stray non-first beat into an empty bank
        for (int k = 0; k < 9; k++) beat(k == 0, rnd_chunk(), 4'd1, 4'd1);
        send_sample(4'd9, 4'd2, 1'b0);
        beat(1'b0, rnd_chunk(), 4'd4, 4'd4);
        send_sample(4'd13, 4'd6, 1'b0);
        repeat (4 * CPC) @(negedge clk);

        // Random samples with random gaps
        for (int s = 0; s < 6; s++) begin
            send_sample(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        repeat (5 * CPC) @(negedge clk);

        // Reset in the middle of a reading block
        send_sample(4'd8, 4'd5, 1'b0);
        w = 0;
        while (!(cyc % CPC == 8 && blk_valid) && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) begin
            n_checks++;
            $display("FAIL midreset_wait: blk_valid got 0 at cnt 8, required 1");
        end
        apply_reset();
        repeat (2 * CPC) @(negedge clk);
        chk("sent_after_midreset", sent_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

endmodule
